// File: rtl/ipod_audio_pkg.sv
// Shared constants, peak state encoding and sample magnitude helper for the audio level path.
package ipod_audio_pkg;

  localparam int unsigned SampleW        = 16;
  localparam int unsigned MagW           = SampleW - 1;
  localparam int unsigned LedW           = 8;
  localparam int unsigned Log2WinDefault = 8;
  localparam int unsigned HoldWinDefault = 4;

  // HOLD while the hold counter is non-zero, DECAY once it has run out.
  typedef enum logic {
    PkDecay = 1'b0,
    PkHold  = 1'b1
  } peak_state_e;

  // Absolute value of a two's-complement sample; the most negative code saturates.
  function automatic logic [MagW-1:0] abs_sat(input logic [SampleW-1:0] s);
    logic [SampleW-1:0] neg;
    neg = ~s + {{(SampleW-1){1'b0}}, 1'b1};
    if (s == {1'b1, {(SampleW-1){1'b0}}}) begin
      return '1;
    end else if (s[SampleW-1]) begin
      return neg[MagW-1:0];
    end else begin
      return s[MagW-1:0];
    end
  endfunction

endpackage

// File: rtl/sample_level_meter_peak_hold.sv
// Peak-hold marker: tracks the top LED of the bar, holds it for a few windows, then decays.
module peak_hold
  import ipod_audio_pkg::*;
#(
  parameter int unsigned HOLD_WIN = HoldWinDefault
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_update,
  input  logic [LedW-1:0] i_led_bar,
  output logic [LedW-1:0] o_peak_led
);

  localparam int unsigned HoldW = (HOLD_WIN < 1) ? 1 : $clog2(HOLD_WIN + 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_WIN);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

  logic [LedW-1:0]  r_peak;
  logic [HoldW-1:0] r_hold_cnt;
  logic [LedW-1:0]  w_newtop;
  logic [LedW-1:0]  w_shift;
  logic [LedW-1:0]  w_decayed;
  peak_state_e      w_state;

  assign w_state   = (r_hold_cnt != '0) ? PkHold : PkDecay;
  assign w_shift   = r_peak >> 1;
  assign w_decayed = (w_shift >= w_newtop) ? w_shift : w_newtop;

  // One-hot of the highest lit LED; later iterations override lower bits.
  always_comb begin
    w_newtop = '0;
    for (int i = 0; i < int'(LedW); i++) begin
      if (i_led_bar[i]) begin
        w_newtop    = '0;
        w_newtop[i] = 1'b1;
      end
    end
  end

  // Peak update, evaluated only when a window result is published.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_peak     <= '0;
      r_hold_cnt <= '0;
    end else if (i_update) begin
      if (w_newtop >= r_peak) begin
        r_peak     <= w_newtop;
        r_hold_cnt <= HoldLoad;
      end else if (w_state == PkHold) begin
        r_hold_cnt <= r_hold_cnt - HoldOne;
      end else begin
        r_peak <= w_decayed;
      end
    end
  end

  assign o_peak_led = r_peak;

endmodule

// File: rtl/sample_level_meter.sv
// Mean-absolute-amplitude meter: windowed average, thermometer LED bar and peak-hold marker.
module sample_level_meter
  import ipod_audio_pkg::*;
#(
  parameter int unsigned LOG2_WIN = Log2WinDefault,
  parameter int unsigned HOLD_WIN = HoldWinDefault
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sample_valid,
  input  logic [SampleW-1:0] i_sample,
  output logic               o_level_valid,
  output logic [MagW-1:0]    o_avg,
  output logic [LedW-1:0]    o_led_bar,
  output logic [LedW-1:0]    o_peak_led
);

  localparam int unsigned AccW   = MagW + LOG2_WIN;
  localparam int unsigned BarLsb = MagW - LedW;
  localparam logic [LOG2_WIN-1:0] CntMax = '1;
  localparam logic [LOG2_WIN-1:0] CntOne = LOG2_WIN'(1);

  logic                r_s1_valid;
  logic [MagW-1:0]     r_s1_abs;
  logic [AccW-1:0]     r_acc;
  logic [LOG2_WIN-1:0] r_cnt;
  logic                r_close;
  logic [AccW-1:0]     r_win_sum;
  logic                r_level_valid;
  logic [MagW-1:0]     r_avg;
  logic [LedW-1:0]     r_led_bar;

  logic                w_last;
  logic [AccW-1:0]     w_sum;
  logic [MagW-1:0]     w_avg;
  logic [LedW-1:0]     w_led;
  logic [LedW-1:0]     w_peak;

  assign w_last = (r_cnt == CntMax);
  assign w_sum  = r_acc + {{LOG2_WIN{1'b0}}, r_s1_abs};
  assign w_avg  = r_win_sum[AccW-1:LOG2_WIN];

  // Stage 1: capture the saturated magnitude of each strobed sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_abs   <= '0;
    end else begin
      r_s1_valid <= i_sample_valid;
      if (i_sample_valid) begin
        r_s1_abs <= abs_sat(i_sample);
      end
    end
  end

  // Stage 2: accumulate; the last sample of a window goes straight into the latched sum.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_close   <= 1'b0;
      r_win_sum <= '0;
    end else begin
      r_close <= r_s1_valid && w_last;
      if (r_s1_valid) begin
        r_cnt <= r_cnt + CntOne;
        if (w_last) begin
          r_win_sum <= w_sum;
          r_acc     <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  // Thermometer bar: LED k lights when avg reaches 2^(BarLsb+k).
  always_comb begin
    w_led = '0;
    for (int k = 0; k < int'(LedW); k++) begin
      w_led[k] = |(w_avg >> (int'(BarLsb) + k));
    end
  end

  // Stage 3: publish the window result; outputs hold between closes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level_valid <= 1'b0;
      r_avg         <= '0;
      r_led_bar     <= '0;
    end else begin
      r_level_valid <= r_close;
      if (r_close) begin
        r_avg     <= w_avg;
        r_led_bar <= w_led;
      end
    end
  end

  peak_hold #(
    .HOLD_WIN (HOLD_WIN)
  ) u_peak_hold (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_update   (r_close),
    .i_led_bar  (w_led),
    .o_peak_led (w_peak)
  );

  assign o_level_valid = r_level_valid;
  assign o_avg         = r_avg;
  assign o_led_bar     = r_led_bar;
  assign o_peak_led    = w_peak;

endmodule

// File: tb/tb_sample_level_meter.sv
// Self-checking bench for sample_level_meter: per-cycle model comparison plus literal scenarios.
module tb_sample_level_meter;

  localparam int LOG2_WIN = 8;
  localparam int HOLD_WIN = 4;
  localparam int WIN      = 1 << LOG2_WIN;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        valid  = 1'b0;
  logic [15:0] sample = 16'h0000;
  logic        o_level_valid;
  logic [14:0] o_avg;
  logic [7:0]  o_led_bar;
  logic [7:0]  o_peak_led;

  sample_level_meter #(
    .LOG2_WIN (LOG2_WIN),
    .HOLD_WIN (HOLD_WIN)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample_valid (valid),
    .i_sample       (sample),
    .o_level_valid  (o_level_valid),
    .o_avg          (o_avg),
    .o_led_bar      (o_led_bar),
    .o_peak_led     (o_peak_led)
  );

  always #5 clk = ~clk;

  int n_checks     = 0;
  int n_fail       = 0;
  int edge_cnt     = 0;
  int lv_count     = 0;
  int last_lv_edge = -1;
  int strobe_edge  = 0;
  int peaks_q[$];

  // Reference model state
  int m_sum, m_cnt, m_hold;
  int pend_due[$];
  int pend_sum[$];
  int e_avg, e_bar, e_peak, e_lv;

  function automatic int mag(input logic [15:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int bar_of(input int a);
    int b;
    b = 0;
    for (int k = 0; k < 8; k++) if ((a >> (7 + k)) != 0) b = b | (1 << k);
    return b;
  endfunction

  function automatic int top_of(input int b);
    int t;
    t = 0;
    for (int k = 0; k < 8; k++) if ((b & (1 << k)) != 0) t = 1 << k;
    return t;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h want %0h", name, edge_cnt, got, want);
    end
  endtask

  // Model step plus per-cycle comparison, 1 time unit after each rising edge.
  initial begin
    logic        c_r, c_v;
    logic [15:0] c_s;
    int          a, nt;
    m_sum = 0; m_cnt = 0; m_hold = 0;
    e_avg = 0; e_bar = 0; e_peak = 0; e_lv = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
      c_r = rst; c_v = valid; c_s = sample;
      if (c_r) begin
        m_sum = 0; m_cnt = 0; m_hold = 0;
        pend_due.delete(); pend_sum.delete();
        e_avg = 0; e_bar = 0; e_peak = 0; e_lv = 0;
      end else begin
        e_lv = 0;
        if (pend_due.size() > 0 && pend_due[0] == edge_cnt) begin
          a = pend_sum[0] / WIN;
          void'(pend_due.pop_front());
          void'(pend_sum.pop_front());
          e_avg = a;
          e_bar = bar_of(a);
          nt    = top_of(e_bar);
          if (nt >= e_peak) begin
            e_peak = nt;
            m_hold = HOLD_WIN;
          end else if (m_hold > 0) begin
            m_hold--;
          end else begin
            e_peak = ((e_peak >> 1) > nt) ? (e_peak >> 1) : nt;
          end
          e_lv = 1;
        end
        if (c_v) begin
          m_sum += mag(c_s);
          m_cnt++;
          if (m_cnt == WIN) begin
            pend_due.push_back(edge_cnt + 2);
            pend_sum.push_back(m_sum);
            m_sum = 0;
            m_cnt = 0;
          end
        end
      end
      #1;
      if (o_level_valid) begin
        lv_count++;
        last_lv_edge = edge_cnt;
        peaks_q.push_back(int'(o_peak_led));
      end
      chk("level_valid", int'(o_level_valid), e_lv);
      chk("avg", int'(o_avg), e_avg);
      chk("led_bar", int'(o_led_bar), e_bar);
      chk("peak_led", int'(o_peak_led), e_peak);
    end
  end

  task automatic drive(input logic r, input logic v, input logic [15:0] s);
    @(negedge clk);
    rst = r; valid = v; sample = s;
    if (v && !r) strobe_edge = edge_cnt + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 16'h0000);
    lv_count = 0;
  endtask

  task automatic window(input logic [15:0] s);
    repeat (WIN) drive(1'b0, 1'b1, s);
  endtask

  task automatic chk_out(input string tag, input int avg, input int bar, input int peak);
    chk({tag, " avg"}, int'(o_avg), avg);
    chk({tag, " led_bar"}, int'(o_led_bar), bar);
    chk({tag, " peak_led"}, int'(o_peak_led), peak);
  endtask

  initial begin
    int want34[13];
    logic [15:0] s;
    logic        v;
    want34 = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04,
               8'h02, 8'h01, 8'h00};

    do_reset();
    idle(1);
    chk("reset level_valid", int'(o_level_valid), 0);
    chk_out("reset", 0, 0, 0);

    // Constant 0x1000, back-to-back
    lv_count = 0;
    window(16'h1000);
    idle(4);
    chk("w1000 pulses", lv_count, 1);
    chk("w1000 latency", last_lv_edge - strobe_edge, 2);
    chk_out("w1000", 4096, 8'h3F, 8'h20);

    // Most negative sample saturates
    lv_count = 0;
    window(16'h8000);
    idle(4);
    chk("w8000 pulses", lv_count, 1);
    chk_out("w8000", 32767, 8'hFF, 8'h80);

    // Peak hold then decay
    do_reset();
    peaks_q.delete();
    window(16'h8000);
    repeat (12) window(16'h0000);
    idle(4);
    chk("decay closes", peaks_q.size(), 13);
    for (int i = 0; i < 13 && i < peaks_q.size(); i++) chk("decay peak", peaks_q[i], want34[i]);
    chk("decay led_bar", int'(o_led_bar), 0);

    // Alternating +/-1000, sparse then dense strobes
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      drive(1'b0, 1'b1, (i % 2 == 0) ? 16'h03E8 : 16'hFC18);
      idle(96);
    end
    idle(4);
    chk("alt sparse pulses", lv_count, 1);
    chk_out("alt sparse", 1000, 8'h07, 8'h04);
    lv_count = 0;
    for (int i = 0; i < WIN; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 16'h03E8 : 16'hFC18);
    idle(4);
    chk("alt dense pulses", lv_count, 1);
    chk_out("alt dense", 1000, 8'h07, 8'h04);

    // Reset mid-window discards the partial window
    do_reset();
    repeat (100) drive(1'b0, 1'b1, 16'h1000);
    drive(1'b1, 1'b0, 16'h0000);
    lv_count = 0;
    repeat (WIN - 1) drive(1'b0, 1'b1, 16'h0100);
    idle(4);
    chk("midreset early pulses", lv_count, 0);
    drive(1'b0, 1'b1, 16'h0100);
    idle(4);
    chk("midreset pulses", lv_count, 1);
    chk_out("midreset", 256, 8'h03, 8'h02);

    // Reset coinciding with the window-closing strobe
    do_reset();
    repeat (WIN - 1) drive(1'b0, 1'b1, 16'h1000);
    drive(1'b1, 1'b1, 16'h1000);
    lv_count = 0;
    idle(6);
    chk("rst-on-close pulses", lv_count, 0);
    chk_out("rst-on-close", 0, 0, 0);

    // Random samples and strobe density, one reset in the middle
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 15))
        0:       s = 16'h8000;
        1:       s = 16'h7FFF;
        2:       s = 16'h0000;
        3, 4:    s = 16'($urandom_range(0, 255));
        default: s = 16'($urandom);
      endcase
      drive(i == 2500, v, s);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_level_meter.md
SAMPLE_LEVEL_METER -- requirements
Module: sample_level_meter

Interface
REQ-001 Parameter LOG2_WIN, default 8: log2 of the number of samples per averaging window (256).
REQ-002 Parameter HOLD_WIN, default 4: count of extra windows the peak indicator holds before it decays.
REQ-003 clk  in  1  system clock (CLK_50M domain); single clock for the whole block.
REQ-004 rst  in  1  reset, synchronous to clk, active-high.
REQ-005 sample_valid  in  1  one-cycle strobe marking a new audio sample (the flash_fsm data_en).
REQ-006 sample  in  16  signed two's-complement audio sample, valid while sample_valid=1.
REQ-007 level_valid  out  1  one-cycle pulse; marks the first cycle that avg, led_bar and peak_led show a new window result.
REQ-008 avg  out  15  unsigned mean absolute amplitude of the last completed window.
REQ-009 led_bar  out  8  thermometer bar of avg; drives LED[9:2].
REQ-010 peak_led  out  8  one-hot peak-hold marker, or zero.

Function
REQ-011 Magnitude: abs = -sample for negative samples, otherwise sample; -32768 shall saturate to 32767; result is 15 bits unsigned.
REQ-012 Pipeline stage 1 shall register abs on every clock edge where sample_valid=1.
REQ-013 Stage 2 shall add the registered abs into a (15+LOG2_WIN)-bit accumulator and increment a LOG2_WIN-bit sample counter.
REQ-014 The block shall accept sample_valid on every cycle (throughput 1/clk) with no loss; results shall not depend on strobe spacing.
REQ-015 Window close: when the counter wraps from 2^LOG2_WIN-1 to 0, avg shall be loaded with (accumulator including this sample) >> LOG2_WIN.
REQ-016 On window close, the accumulator shall restart at 0; the next window contains only subsequent samples, with no gap or overlap.
REQ-017 Latency: avg, led_bar and peak_led update, and level_valid=1, on the 2nd rising edge after the edge that samples the window's last strobe.
REQ-018 led_bar[k] = OR of avg[14:7+k], for k=0..7; no other encoding.
REQ-019 Peak: newtop = one-hot of the highest set bit of the new led_bar, or 0 if the bar is empty.
REQ-020 Peak states: HOLD (hold_cnt>0) and DECAY (hold_cnt=0); evaluated only on window close.
REQ-021 If newtop >= peak_led: peak_led <= newtop, hold_cnt <= HOLD_WIN, state HOLD.
REQ-022 Else, in HOLD: hold_cnt decrements; peak_led is unchanged.
REQ-023 Else, in DECAY: peak_led <= max(peak_led >> 1, newtop); bit0 decays to 0.
REQ-024 Outputs shall hold their value between window closes.

Reset
REQ-025 rst=1 shall clear the stage-1 register, accumulator, counter, avg, led_bar, peak_led, hold_cnt and level_valid to 0, and set the peak state to DECAY.
REQ-026 rst has priority over a simultaneous sample_valid.
REQ-027 Reset mid-window shall discard the partial window; the first window after reset needs a full 2^LOG2_WIN strobes.
REQ-028 No level_valid pulse shall be produced by strobes in flight at reset.

Structure
REQ-029 Shared package ipod_audio_pkg holds the sample width (16), the LED bar width (8), the LOG2_WIN and HOLD_WIN defaults, and the peak state enum.
REQ-030 Peak logic shall be a sub-module named peak_hold (inputs: clk, rst, update strobe, led_bar; output: peak_led).

Verification
REQ-031 Strobe sample=16'h1000 256 times, back-to-back -> exactly one level_valid, 2 edges after the last strobe; avg=4096, led_bar=8'h3F, peak_led=8'h20.
REQ-032 Strobe 256 samples of -32768 -> avg=32767, led_bar=8'hFF, peak_led=8'h80.
REQ-033 Strobe alternating +1000/-1000 with sample_valid every 1134 cycles -> avg=1000, led_bar=8'h07; repeated with strobes every cycle -> identical result.
REQ-034 One window of -32768, then windows of 0 -> peak_led=8'h80 for 5 closes (load + 4 holds), then 8'h40, 8'h20, ..., 8'h01, then 8'h00; led_bar=0 from the 2nd close onward.
REQ-035 Strobe 100 samples of 16'h1000, assert rst 1 cycle, then 256 samples of 16'h0100 -> no level_valid before the 256th post-reset strobe; avg=256, led_bar=8'h03.
REQ-036 Assert rst in the same cycle as a window-closing strobe -> level_valid stays 0 and all outputs read 0.
